// File: rtl/sync_filter_n_pkg.sv
// Shared constants for the async-boundary synchronizers used ahead of the USB RX logic.
// RX blocks take their default depth and filter length from here so they instantiate consistently.
package sync_filter_n_pkg;

  localparam int SF_STAGES     = 2;
  localparam int SF_FILTER_LEN = 3;

  // Filter counter width: $clog2(FILTER_LEN), never narrower than one bit.
  function automatic int sf_cnt_width(input int flen);
    return (flen <= 1) ? 1 : $clog2(flen);
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One synchronizer channel: flop chain, consecutive-sample glitch filter and
// registered rise/fall pulses aligned with the filtered output change.
module sync_filter_bit
  import sync_filter_n_pkg::*;
#(
  parameter int   STAGES     = SF_STAGES,
  parameter int   FILTER_LEN = SF_FILTER_LEN,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = sf_cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [STAGES-1:0] r_chain;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_filt;
  logic              r_rise;
  logic              r_fall;

  logic w_sync;
  logic w_differ;
  logic w_update;

  assign w_sync   = r_chain[STAGES-1];
  assign w_differ = w_sync ^ r_filt;
  // The counter is cleared on every update, so it never has to wrap.
  assign w_update = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_chain <= {STAGES{RST_VAL}};
      r_cnt   <= '0;
      r_filt  <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], async_in};
      if (!w_differ || w_update) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_update) begin
        r_filt <= w_sync;
      end
      r_rise <= w_update & w_sync;
      r_fall <= w_update & ~w_sync;
    end
  end

  assign sync_out   = w_sync;
  assign filt_out   = r_filt;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/sync_filter_n.sv
// Multi-channel synchronizer with glitch filter and edge pulses; every output is a flop.
// Channels are fully independent, one sync_filter_bit per bit of async_in.
module sync_filter_n
  import sync_filter_n_pkg::*;
#(
  parameter int               WIDTH      = 2,
  parameter int               STAGES     = SF_STAGES,
  parameter int               FILTER_LEN = SF_FILTER_LEN,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_bit #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RST_VAL    (RESET_VAL[i])
    ) u_bit (
      .clk        (clk),
      .n_rst      (n_rst),
      .async_in   (async_in[i]),
      .sync_out   (sync_out[i]),
      .filt_out   (filt_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

endmodule

// File: doc/sync_filter_n.md
Name: sync_filter_n

Overview:
Parametrised multi-channel synchronizer for asynchronous inputs such as USB D+/D- line samples and external strobes. Each channel has:
- a configurable-depth flop chain with a per-bit reset value;
- a consecutive-sample glitch filter;
- single-cycle rising and falling edge pulses.

It sits at the chip/async boundary, ahead of the USB receive logic, and replaces per-signal hand-instantiated synchronizers.

Parameters:
WIDTH, 2, number of independent channels (>=1)
STAGES, 2, synchronizer flops per channel (>=2)
FILTER_LEN, 3, consecutive disagreeing samples required before the filtered output changes (>=1)
RESET_VAL, {WIDTH{1'b1}}, per-channel reset value of all sync stages and filt_out (bit i applies to channel i)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous, active-low reset
async_in  input  WIDTH  asynchronous inputs, no timing relation to clk
sync_out  output  WIDTH  raw synchronized value, i.e. last stage of each chain
filt_out  output  WIDTH  glitch-filtered synchronized value
rise_pulse  output  WIDTH  one-cycle pulse on a filt_out 0->1 transition
fall_pulse  output  WIDTH  one-cycle pulse on a filt_out 1->0 transition

Behaviour:
- Reset is asynchronous and active-low. While n_rst=0:
  - every sync stage of channel i = RESET_VAL[i];
  - filt_out[i] = RESET_VAL[i];
  - filter counters = 0;
  - rise_pulse = fall_pulse = 0.
- No edge pulse may be generated as a result of reset assertion or release.
- Sync chain, per channel: stage0 <= async_in[i]; stage k <= stage k-1; sync_out[i] = stage STAGES-1. A stable input change appears on sync_out exactly STAGES rising edges later.
- Filter, per channel: counter cnt, width $clog2(FILTER_LEN) (minimum 1 bit). Each cycle:
  - if sync_out[i] == filt_out[i]: cnt <= 0;
  - else if cnt == FILTER_LEN-1: filt_out[i] <= sync_out[i], cnt <= 0;
  - else: cnt <= cnt+1.
- Filter consequences:
  - filt_out changes only after sync_out has differed from it for FILTER_LEN consecutive cycles.
  - Any agreeing sample restarts the count.
  - FILTER_LEN=1 makes filt_out a plain one-cycle delay of sync_out.
- Total latency, async_in step to filt_out: STAGES + FILTER_LEN edges.
- Edge pulses are registered and are high in the same cycle filt_out takes its new value, for exactly one cycle:
  - rise_pulse[i] <= (filter updating this cycle) & sync_out[i];
  - fall_pulse[i] <= (filter updating this cycle) & ~sync_out[i].
  - rise and fall of one channel are never high together.
- Back-to-back transitions: the minimum spacing between pulses on one channel is FILTER_LEN cycles. The counter never wraps; it saturates by design at FILTER_LEN-1 because it resets on update.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Reset mid-count: the counter is discarded and outputs return to RESET_VAL. After release, a held input differing from RESET_VAL needs the full STAGES + FILTER_LEN latency again, then produces exactly one pulse.
- All outputs come directly from flops; there is no combinational path from async_in to any output.

Decomposition:
- No shared package types required. RESET_VAL width follows WIDTH.
- The default constants (STAGES=2, FILTER_LEN=3) go in the project's common usb constants package so RX blocks instantiate consistently.
- One natural sub-module, sync_filter_bit: one channel with chain, counter, filt flop and pulse flops, taking STAGES, FILTER_LEN and a 1-bit RST_VAL. The top is a generate loop over WIDTH.

Test Plan:
1. Defaults, async_in=2'b11, pulse n_rst low mid-cycle -> all outputs 2'b11 / 0 immediately, before the next clk edge; no pulses for 10 cycles after release.
2. Channel 0 steps 1->0 just after edge 0 and holds:
   - sync_out[0]=0 after edge 2;
   - filt_out[0]=0 after edge 5;
   - fall_pulse[0]=1 for the single cycle after edge 5;
   - channel 1 untouched.
3. Channel 1 low for 2 cycles then high again (post-sync glitch width 2 < FILTER_LEN=3) -> sync_out[1] dips, filt_out[1] stays 1, no pulses. Repeat with width 3 -> filt_out[1] falls and one fall_pulse fires.
4. Both channels toggle 1->0 on the same edge, then 0->1 ten cycles later -> fall_pulse=2'b11 for one cycle, then rise_pulse=2'b11 for one cycle; rise and fall never overlap.
5. Channel 0 step 1->0, assert n_rst after sync_out[0]=0 with cnt=1, release with input still 0 -> filt_out[0]=1 during reset. Then exactly one fall_pulse, 5 edges after release.
6. Variant STAGES=3, FILTER_LEN=1, RESET_VAL=2'b00: channel 0 step 0->1 -> filt_out[0] and rise_pulse[0] assert 4 edges later; a 1-cycle post-sync glitch passes through as a rise then a fall pulse.
